if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00000000, the PC value loaded at reset.
REQ-002 The module SHALL have parameter NOP_INST, default 32'h00000000, the instruction word presented on a bubble.
REQ-003 The module SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1, the reset: asynchronous and active-low.
REQ-005 The module SHALL have port start_i, input, 1, high to enable fetching; low holds PC and inserts bubbles.
REQ-006 The module SHALL have port stall_i, input, 1, the hazard-unit hold for PC and the IF/ID register.
REQ-007 The module SHALL have port flush_i, input, 1, which squashes the IF/ID contents to a bubble.
REQ-008 The module SHALL have port redirect_i, input, 1, which takes redirect_pc_i as the next PC (jump/branch taken).
REQ-009 The module SHALL have port redirect_pc_i, input, 32, the target from the jump/branch select mux.
REQ-010 The module SHALL have port inst_addr_o, output, 32, the instruction memory address, equal to the current PC.
REQ-011 The module SHALL have port inst_i, input, 32, the instruction memory read data, combinational from inst_addr_o.
REQ-012 The module SHALL have port pc_plus4_o, output, 32, the combinational PC+4 of the current PC, which sources the upper 4 bits for jump-target formation.
REQ-013 The module SHALL have port ifid_pc_plus4_o, output, 32, the registered PC+4 for ID.
REQ-014 The module SHALL have port ifid_inst_o, output, 32, the registered instruction for ID.
REQ-015 The module SHALL have port ifid_valid_o, output, 1, high when the IF/ID register holds a real instruction.
REQ-016 The module SHALL have port misalign_o, output, 1, a sticky flag set when an accepted redirect target has bits [1:0] not equal to 0.

Function
REQ-017 The FSM SHALL have states IDLE and RUN; reset enters IDLE; IDLE moves to RUN on start_i=1; RUN returns to IDLE on start_i=0.
REQ-018 In IDLE the PC SHALL hold and each edge SHALL load the IF/ID register with a bubble (valid=0, inst=NOP_INST, pc_plus4=0).
REQ-019 In RUN the next PC SHALL follow this priority: redirect_i gives redirect_pc_i, else stall_i holds PC, else PC+4.
REQ-020 Redirect SHALL override stall for the PC update.
REQ-021 In RUN the IF/ID register SHALL follow this priority: flush_i loads a bubble, else stall_i holds, else it loads {pc_plus4, inst_i, valid=1}.
REQ-022 On simultaneous flush_i and stall_i, flush SHALL win.
REQ-023 Fetch latency SHALL be 1 cycle: the instruction at PC appears on ifid_* after the next edge.
REQ-024 The PC+4 adder SHALL be 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000 without a flag.
REQ-025 misalign_o SHALL set on an edge where redirect_i=1 with redirect_pc_i[1:0] not equal to 0, and SHALL clear only on reset.
REQ-026 A misaligned target SHALL still be loaded into the PC unmodified.
REQ-027 The transition into RUN on start_i SHALL fetch from the held PC on the following edge with no skipped address.

Reset
REQ-028 Asserting rst_i low SHALL immediately set PC=RESET_PC, state=IDLE, ifid_valid_o=0, ifid_inst_o=NOP_INST, ifid_pc_plus4_o=0, misalign_o=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending update.
REQ-030 Operation SHALL resume from RESET_PC after release and start_i.

Structure
REQ-031 RESET_PC and NOP_INST defaults and the FSM state encoding SHALL live in the shared CPU package.
REQ-032 One sub-module, pc_reg, SHALL hold the PC with async active-low reset, load enable and next-PC input.
REQ-033 The FSM and the IF/ID register SHALL be implemented in if_stage.

Verification
REQ-034 The bench SHALL cover: reset, start_i=1 for 4 cycles with no stall -> inst_addr_o 0,4,8,C and ifid_pc_plus4_o trailing by one cycle (4,8,C).
REQ-035 The bench SHALL cover: stall_i=1 for 2 cycles at PC=8 -> PC stays 8 and the IF/ID contents are unchanged; fetch of 8 resumes after release.
REQ-036 The bench SHALL cover: redirect_i=1, redirect_pc_i=32'h00000040 with flush_i=1 -> next PC 40, ifid_valid_o=0 for one cycle, then inst@40 valid.
REQ-037 The bench SHALL cover: redirect and stall in the same cycle -> PC takes the target; with flush+stall -> IF/ID becomes a bubble.
REQ-038 The bench SHALL cover: redirect_pc_i=32'h00000042 -> misalign_o=1 and stays 1 through later cycles until rst_i low.
REQ-039 The bench SHALL cover: PC=32'hFFFFFFFC running -> next PC 0; rst_i pulsed low mid-run -> outputs reach reset values before the next clock edge.

Source files
------------

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared CPU package for the instruction-fetch stage. Holds the
//               reset PC and bubble instruction defaults, the fetch FSM state
//               encoding and the PC increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INST = 32'h0000_0000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } if_state_e;

    // Modulo-2^32 increment; the carry out of bit 31 is intentionally dropped.
    function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Control, instruction-memory and IF/ID bundle of the fetch
//               stage.
//               slave  : the fetch stage side (control/inst in, PC/IF-ID out)
//               master : the pipeline/memory side driving control and inst.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;

    logic        start_i;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i;
    logic [31:0] pc_plus4_o;
    logic [31:0] ifid_pc_plus4_o;
    logic [31:0] ifid_inst_o;
    logic        ifid_valid_o;
    logic        misalign_o;

    modport slave (
        input  start_i, stall_i, flush_i, redirect_i, redirect_pc_i, inst_i,
        output inst_addr_o, pc_plus4_o, ifid_pc_plus4_o, ifid_inst_o,
               ifid_valid_o, misalign_o
    );

    modport master (
        output start_i, stall_i, flush_i, redirect_i, redirect_pc_i, inst_i,
        input  inst_addr_o, pc_plus4_o, ifid_pc_plus4_o, ifid_inst_o,
               ifid_valid_o, misalign_o
    );

endinterface : if_stage_if
`default_nettype wire

// File: rtl/if_stage_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter register with load enable.
//   clk_i  in   clock, rising edge
//   rst_i  in   asynchronous active-low reset, loads RESET_PC
//   en_i   in   load enable
//   pc_d_i in   next PC value
//   pc_q_o out  current PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        en_i,
    input  wire logic [31:0] pc_d_i,
    output logic      [31:0] pc_q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= pc_d_i;
        end
    end

    assign pc_q_o = pc_q;

endmodule : pc_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage: PC register, IDLE/RUN fetch FSM and
//               the IF/ID pipeline register.
//   clk_i  in   clock, rising edge
//   rst_i  in   asynchronous active-low reset
//   bus    slave modport of if_stage_if:
//            start_i, stall_i, flush_i, redirect_i, redirect_pc_i, inst_i in
//            inst_addr_o, pc_plus4_o, ifid_pc_plus4_o, ifid_inst_o,
//            ifid_valid_o, misalign_o out
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_INST = c_NOP_INST
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    if_stage_if.slave bus
);

    if_state_e   state_q, state_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misalign_q, misalign_d;

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_d;
    logic        w_pc_en;
    logic        w_run;

    // Fetch only happens while in RUN with start_i still high; dropping
    // start_i freezes the PC on the same edge that returns the FSM to IDLE.
    assign w_run      = (state_q == S_RUN) && bus.start_i;
    assign w_pc_plus4 = pc_inc4(w_pc);

    // Redirect beats stall: a taken branch must not be lost to a hazard hold.
    assign w_pc_en = w_run && (bus.redirect_i || !bus.stall_i);
    assign w_pc_d  = bus.redirect_i ? bus.redirect_pc_i : w_pc_plus4;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (w_pc_en),
        .pc_d_i (w_pc_d),
        .pc_q_o (w_pc)
    );

    always_comb begin
        state_d         = state_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_valid_d    = ifid_valid_q;
        // Sticky: only reset clears it. Misaligned targets still load as-is.
        misalign_d      = misalign_q |
                          (w_run && bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00));

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_RUN;
                end
                ifid_pc_plus4_d = 32'h0000_0000;
                ifid_inst_d     = NOP_INST;
                ifid_valid_d    = 1'b0;
            end
            S_RUN: begin
                if (!bus.start_i) begin
                    state_d         = S_IDLE;
                    ifid_pc_plus4_d = 32'h0000_0000;
                    ifid_inst_d     = NOP_INST;
                    ifid_valid_d    = 1'b0;
                end else if (bus.flush_i) begin
                    // Flush wins over stall: a squashed slot must not linger.
                    ifid_pc_plus4_d = 32'h0000_0000;
                    ifid_inst_d     = NOP_INST;
                    ifid_valid_d    = 1'b0;
                end else if (!bus.stall_i) begin
                    ifid_pc_plus4_d = w_pc_plus4;
                    ifid_inst_d     = bus.inst_i;
                    ifid_valid_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= S_IDLE;
            ifid_pc_plus4_q <= 32'h0000_0000;
            ifid_inst_q     <= NOP_INST;
            ifid_valid_q    <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_valid_q    <= ifid_valid_d;
            misalign_q      <= misalign_d;
        end
    end

    assign bus.inst_addr_o     = w_pc;
    assign bus.pc_plus4_o      = w_pc_plus4;
    assign bus.ifid_pc_plus4_o = ifid_pc_plus4_q;
    assign bus.ifid_inst_o     = ifid_inst_q;
    assign bus.ifid_valid_o    = ifid_valid_q;
    assign bus.misalign_o      = misalign_q;

endmodule : if_stage
`default_nettype wire
